// File: rtl/dct_seq_ctrl.sv
// dct_seq_ctrl: address and strobe sequencer for the MFCC DCT stage.
// One start pulse walks every (k, n) pair, one per cycle with no bubbles.
// Each pair issues a log-mel read address and a cosine-ROM read address.
// The accumulator load/add strobes are delayed by MUL_LAT to line up with the
// product. Each finished coefficient is flagged one cycle after its last add.
//
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   start       - one-cycle frame request, ignored while busy
//   busy        - high from the first issue cycle through the done cycle
//   done        - pulse coincident with the final cep_valid
//   mel_addr    - log-mel buffer read address (n)
//   cos_addr    - cosine ROM read address (k*N_FILT + n), running counter
//   acc_new     - accumulator load strobe (first term of a coefficient)
//   acc_en      - accumulator add strobe (remaining terms)
//   cep_valid   - accumulator holds finished coefficient cep_idx
//   cep_idx     - coefficient index k accompanying cep_valid
//
// Build option: define DCT_SKIP_C0_EN to skip coefficient 0 (k starts at 1).

module dct_seq_ctrl #(
    parameter int unsigned N_FILT  = 26,
    parameter int unsigned N_CEP   = 13,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned AW_MEL  = 5,
    parameter int unsigned AW_COS  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW_MEL-1:0] mel_addr,
    output logic [AW_COS-1:0] cos_addr,
    output logic              acc_new,
    output logic              acc_en,
    output logic              cep_valid,
    output logic [3:0]        cep_idx
);

`ifdef DCT_SKIP_C0_EN
    localparam int unsigned K0 = 1;
`else
    localparam int unsigned K0 = 0;
`endif

    localparam int unsigned       IW       = 4;
    localparam logic [AW_MEL-1:0] N_LAST   = AW_MEL'(N_FILT - 1);
    localparam logic [IW-1:0]     K_FIRST  = IW'(K0);
    localparam logic [IW-1:0]     K_LAST   = IW'(N_CEP - 1);
    localparam logic [AW_COS-1:0] COS_BASE = AW_COS'(K0 * N_FILT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic                busy_q;
    logic [AW_MEL-1:0]   n_q;
    logic [IW-1:0]       k_q;
    logic [AW_COS-1:0]   cos_q;

    // Strobe delay lines: acc_* need MUL_LAT stages, end-of-coefficient one more
    logic [MUL_LAT-1:0]        new_sr;
    logic [MUL_LAT-1:0]        en_sr;
    logic [MUL_LAT:0]          end_sr;
    logic [MUL_LAT:0]          fin_sr;
    logic [MUL_LAT:0][IW-1:0]  idx_sr;

    logic issue;
    logic n_last;
    logic pair_last;

    assign issue     = (state == RUN);
    assign n_last    = (n_q == N_LAST);
    assign pair_last = n_last && (k_q == K_LAST);

    // FSM, issue counters and strobe pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            n_q    <= '0;
            k_q    <= K_FIRST;
            cos_q  <= COS_BASE;
            new_sr <= '0;
            en_sr  <= '0;
            end_sr <= '0;
            fin_sr <= '0;
            idx_sr <= '0;
        end else begin
            new_sr[0] <= issue && (n_q == '0);
            en_sr[0]  <= issue && (n_q != '0);
            end_sr[0] <= issue && n_last;
            fin_sr[0] <= issue && pair_last;
            // Index is only carried with its end strobe so cep_idx idles at 0
            idx_sr[0] <= (issue && n_last) ? k_q : '0;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                new_sr[i] <= new_sr[i-1];
                en_sr[i]  <= en_sr[i-1];
            end
            for (int i = 1; i <= int'(MUL_LAT); i++) begin
                end_sr[i] <= end_sr[i-1];
                fin_sr[i] <= fin_sr[i-1];
                idx_sr[i] <= idx_sr[i-1];
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (pair_last) begin
                        // Rewind counters so the next frame starts from base
                        state <= DRAIN;
                        n_q   <= '0;
                        k_q   <= K_FIRST;
                        cos_q <= COS_BASE;
                    end else begin
                        cos_q <= cos_q + AW_COS'(1);
                        if (n_last) begin
                            n_q <= '0;
                            k_q <= k_q + IW'(1);
                        end else begin
                            n_q <= n_q + AW_MEL'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Leave on the done cycle; a start seen here is dropped
                    if (fin_sr[MUL_LAT]) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = fin_sr[MUL_LAT];
    assign mel_addr  = n_q;
    assign cos_addr  = cos_q;
    assign acc_new   = new_sr[MUL_LAT-1];
    assign acc_en    = en_sr[MUL_LAT-1];
    assign cep_valid = end_sr[MUL_LAT];
    assign cep_idx   = idx_sr[MUL_LAT];

endmodule

// File: tb/tb_dct_seq_ctrl.sv
// Directed bench for dct_seq_ctrl: default instance (MUL_LAT=2) checked cycle by
// cycle against hand-derived timing, plus a MUL_LAT=4 instance driving a
// reference ROM/multiplier/accumulator model checked against golden DCT sums.
module tb_dct_seq_ctrl;

    localparam int N_FILT = 26;
    localparam int N_CEP  = 13;
    localparam int MUL    = 2;
`ifdef DCT_SKIP_C0_EN
    localparam int K0 = 1;
`else
    localparam int K0 = 0;
`endif
    localparam int NCOEF    = N_CEP - K0;
    localparam int ISS      = NCOEF * N_FILT;
    localparam int DONE_CYC = ISS + MUL + 1;
    localparam int COS0     = K0 * N_FILT;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy, done, acc_new, acc_en, cep_valid;
    logic [4:0] mel_addr;
    logic [8:0] cos_addr;
    logic [3:0] cep_idx;
    logic       busy4, done4, acc_new4, acc_en4, cep_valid4;
    logic [4:0] mel_addr4;
    logic [8:0] cos_addr4;
    logic [3:0] cep_idx4;

    int n_err = 0;
    int n_chk = 0;
    int n_cep4 = 0;

    logic [7:0]  mel_m [32];
    logic [7:0]  cos_m [512];
    logic [31:0] prod_sr [4];
    logic [31:0] acc_m;

    dct_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mel_addr(mel_addr), .cos_addr(cos_addr), .acc_new(acc_new),
        .acc_en(acc_en), .cep_valid(cep_valid), .cep_idx(cep_idx)
    );

    dct_seq_ctrl #(.MUL_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .busy(busy4), .done(done4),
        .mel_addr(mel_addr4), .cos_addr(cos_addr4), .acc_new(acc_new4),
        .acc_en(acc_en4), .cep_valid(cep_valid4), .cep_idx(cep_idx4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference datapath: ROM + multiplier take 4 cycles, accumulator register after
    always @(posedge clk) begin
        prod_sr[0] <= 32'(mel_m[mel_addr4]) * 32'(cos_m[cos_addr4]);
        for (int i = 1; i < 4; i++) prod_sr[i] <= prod_sr[i-1];
        if (acc_new4)     acc_m <= prod_sr[3];
        else if (acc_en4) acc_m <= acc_m + prod_sr[3];
    end

    function automatic logic [31:0] golden(input int k);
        logic [31:0] s;
        s = '0;
        for (int n = 0; n < N_FILT; n++)
            s = s + 32'(mel_m[n]) * 32'(cos_m[k*N_FILT + n]);
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        check("excl_lat2", 32'(acc_new & acc_en), 32'(0));
        check("excl_lat4", 32'(acc_new4 & acc_en4), 32'(0));
        if (cep_valid4) begin
            n_cep4++;
            check("sum_lat4", acc_m, golden(int'(cep_idx4)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_zero"}, 32'({busy, done, acc_new, acc_en, cep_valid, cep_idx, mel_addr}), 32'(0));
        check({tag, "_cos"}, 32'(cos_addr), 32'(COS0));
        check({tag, "_zero4"}, 32'({busy4, done4, acc_new4, acc_en4, cep_valid4, cep_idx4, mel_addr4}), 32'(0));
        check({tag, "_cos4"}, 32'(cos_addr4), 32'(COS0));
    endtask

    // Issue one start and check the whole frame cycle by cycle
    task automatic run_frame();
        int  c_new, c_en, j;
        bit  ev, nw_exp, en_exp;
        c_new = 0;
        c_en  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= DONE_CYC + 4; i++) begin
            check("busy", 32'(busy), 32'(i <= DONE_CYC));
            check("done", 32'(done), 32'(i == DONE_CYC));
            if (i <= ISS) begin
                check("cos_addr", 32'(cos_addr), 32'(COS0 + i - 1));
                check("mel_addr", 32'(mel_addr), 32'((i - 1) % N_FILT));
            end
            j  = i - MUL - 1;
            ev = (j > 0) && (j % N_FILT == 0) && (j / N_FILT <= NCOEF);
            check("cep_valid", 32'(cep_valid), 32'(ev));
            if (ev) check("cep_idx", 32'(cep_idx), 32'(K0 + j / N_FILT - 1));
            nw_exp = (i > MUL) && (i <= ISS + MUL) && ((i - 1 - MUL) % N_FILT == 0);
            en_exp = (i > MUL) && (i <= ISS + MUL) && !nw_exp;
            check("acc_new", 32'(acc_new), 32'(nw_exp));
            check("acc_en", 32'(acc_en), 32'(en_exp));
            c_new += int'(acc_new);
            c_en  += int'(acc_en);
            tick();
        end
        check("n_acc_new", 32'(c_new), 32'(NCOEF));
        check("n_acc_en", 32'(c_en), 32'(NCOEF * (N_FILT - 1)));
    endtask

    initial begin
        int  rises, second, t;
        logic prev_busy;

        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 32; i++)  mel_m[i] = 8'($urandom);
        for (int i = 0; i < 512; i++) cos_m[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            check_reset_outputs("idle");
        end

        // Single frame
        run_frame();

        // start held high: exactly two frames, second issue at cycle ISS+5
        rises     = 0;
        second    = 0;
        prev_busy = 1'b0;
        start     = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (busy && !prev_busy) begin
                rises++;
                if (rises == 2) second = i;
            end
            if (i == 1) check("held_first_issue", 32'({busy, mel_addr}), 32'({1'b1, 5'd0}));
            prev_busy = busy;
        end
        start = 1'b0;
        check("held_frames", 32'(rises), 32'(2));
        check("held_second_start", 32'(second), 32'(ISS + 5));
        t = 0;
        while ((busy || busy4) && t < 2000) begin
            tick();
            t++;
        end
        check("drain_timeout", 32'(t < 2000), 32'(1));

        // Reset at issue cycle 100
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        check("pre_reset_busy", 32'({busy, cos_addr}), 32'({1'b1, 9'(COS0 + 99)}));
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset_quiet", 32'({busy, done, acc_new, acc_en, cep_valid,
                                            busy4, done4, acc_new4, acc_en4, cep_valid4}), 32'(0));
        end
        run_frame();

        check("lat4_coefs_seen", 32'(n_cep4 >= NCOEF), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dct_seq_ctrl.md
# dct_seq_ctrl

Sequencer for the MFCC DCT stage. On a `start` pulse it walks every (cepstral index k, filter index n) pair. For each pair it issues read addresses to the log-mel buffer and the cosine-coefficient ROM. It also drives the new/enable strobes of the DCT accumulator, delayed to match the multiplier pipeline, and flags each finished coefficient so the downstream cepstral register can capture the accumulator output. It sits between the filterbank log stage and the cepstral output buffer and is the only master of the accumulator controls.

## Interface
Parameters:
- `N_FILT`, 26: filters per frame, i.e. terms per coefficient.
- `N_CEP`, 13: cepstral coefficients per frame.
- `MUL_LAT`, 2: cycles from address issue to the product being present at the accumulator input (ROM read plus multiplier). Range 1..4.
- `AW_MEL`, 5: mel buffer address width.
- `AW_COS`, 9: cosine ROM address width. Must satisfy N_CEP*N_FILT <= 2^AW_COS.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle frame start request. Ignored while `busy`.
- `busy` out 1: high from the first issue cycle through the `done` cycle.
- `done` out 1: one-cycle pulse when the final coefficient is valid.
- `mel_addr` out AW_MEL: mel buffer read address n.
- `cos_addr` out AW_COS: cosine ROM address k*N_FILT+n.
- `acc_new` out 1: accumulator load strobe (first term of a coefficient).
- `acc_en` out 1: accumulator add strobe (remaining terms).
- `cep_valid` out 1: accumulator output holds the finished coefficient `cep_idx` this cycle.
- `cep_idx` out 4: index k of the coefficient flagged by `cep_valid`.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE --start--> RUN.
  - RUN --last (k,n) issued--> DRAIN.
  - DRAIN --final cep_valid--> IDLE.
- RUN issues one (k,n) per cycle with no bubbles.
  - n counts 0..N_FILT-1 and wraps to 0, incrementing k.
  - k counts from K0 to N_CEP-1. K0 = 0, or 1 with the configuration macro enabled.
  - `cos_addr` is a running counter starting at K0*N_FILT and incrementing by 1. No multiplier is used.
  - `mel_addr` equals n.
- Issue strobes are delayed through a MUL_LAT-deep shift register:
  - `acc_new` is the delayed (n==0) strobe.
  - `acc_en` is the delayed (n!=0) strobe.
  - The two are never high together.
- `cep_valid` is the delayed (n==N_FILT-1) strobe plus one further cycle, so it lands when the accumulator register holds the completed sum. `cep_idx` travels alongside it in the same pipeline.
- Back-to-back coefficients are legal. `cep_valid` for k coincides with `acc_new` for k+1, and the accumulator output still holds k's sum in that cycle.
- `done` pulses coincident with the last `cep_valid`.
- `start` arriving in RUN or DRAIN is dropped, not queued. `start` in the same cycle as `done` is also dropped.
- Reset values: state IDLE, all counters 0, delay pipeline cleared. Every output is 0, except `cos_addr` = K0*N_FILT.
- Reset mid-frame: all outputs return to reset values asynchronously. No residual `acc_*` or `cep_valid` pulses appear after release.

## Timing
- `start` is sampled at edge E0. Issue cycle 1 is the cycle after E0: `busy`=1, n=0, k=K0.
- `acc_new` for the first term is high in cycle 1+MUL_LAT.
- Coefficient k's last term issues at cycle c = (k-K0+1)*N_FILT. Its `cep_valid` is in cycle c+MUL_LAT+1.
- Default parameters, K0=0: 338 issue cycles. `done` and the final `cep_valid` fall in cycle 341. `busy` is low from cycle 342.
- Earliest accepted restart: `start` sampled in the cycle after `done`.

## Configuration
- `DCT_SKIP_C0_EN` defined: K0=1. Coefficient 0 is never issued. `cos_addr` starts at N_FILT. N_CEP-1 coefficients are produced with `cep_idx` 1..N_CEP-1. Default frame is 312 issue cycles, with `done` in cycle 315.
- Undefined: K0=0, producing all N_CEP coefficients, `cep_idx` 0..N_CEP-1.

## Test plan
- Reset, then idle 20 cycles. Expect all outputs at reset values and `busy`=0 throughout.
- Single `start` (defaults, macro off):
  - exactly 13 `acc_new` and 325 `acc_en` pulses;
  - `cos_addr` runs 0..337 contiguously;
  - `cep_valid` in cycles 29, 55, …, 341 with `cep_idx` 0..12;
  - `done` in cycle 341.
- `start` held high for 400 cycles from IDLE. Expect exactly two frames: the second begins at issue cycle 343, and no `start` is accepted while `busy`.
- Assert `rst` at issue cycle 100, then `start` 5 cycles after release. Expect outputs at 0 immediately, no stray strobes, and a clean full frame afterwards.
- `MUL_LAT`=4 with a reference accumulator model and random mel/ROM data. Expect each `cep_valid` value to match the golden DCT sum, and `acc_new`/`acc_en` never both high.
- `DCT_SKIP_C0_EN` defined. Expect first `cos_addr` = 26, `cep_idx` 1..12 only, and `done` in cycle 315.
